uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver for the UART IO block. Deserialises 8N1 frames from the `rxd` pin using 16x oversampling.
- Delivers each received byte as a one-cycle write strobe into the RX FIFO, which the system bus reads via memory-mapped IO.
- Sits directly upstream of the RX FIFO. It is the receive-side counterpart of the TX FIFO / transmitter path.
- Reports framing and overrun errors to the IO register layer.

Parameters:
- BAUD_DIV, 27, clk cycles per oversample tick. 50 MHz / (115200 × 16) ≈ 27. Legal range ≥ 2.
- DATA_BITS, 8, data bits per frame, LSB first.
- OVERSAMPLE, 16, ticks per bit period. Fixed; not overridable.

Ports:
- clk  input  1  system clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial input; idle high.
- rx_fifo_full  input  1  RX FIFO full flag.
- err_clr  input  1  one-cycle pulse; clears the sticky overrun_err.
- rx_data  output  DATA_BITS  received byte; valid while rx_valid = 1.
- rx_valid  output  1  one-cycle pulse; acts as the RX FIFO write enable.
- framing_err  output  1  one-cycle pulse; stop bit sampled low.
- overrun_err  output  1  sticky; a byte was dropped because the FIFO was full.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high.
  - Reset values: rx_data = 0, rx_valid = 0, framing_err = 0, overrun_err = 0, busy = 0.
  - Both synchroniser flops reset to 1. State = IDLE. All counters = 0.
  - Reset asserted mid-frame abandons the frame: no rx_valid and no error pulse.
- Input synchroniser:
  - rxd passes through 2 flops to give rxd_s.
  - Only rxd_s is used internally.
- Tick generator:
  - Counter runs 0..BAUD_DIV-1. A tick is a one-clk pulse when the count equals BAUD_DIV-1; the count then wraps to 0.
  - The counter and the tick counter (0..15) are forced to 0 in IDLE. This aligns sampling to the start edge.
- IDLE:
  - rxd_s = 0 → START.
- START:
  - After 8 ticks (mid start bit), sample rxd_s.
  - rxd_s = 0 → DATA, with bit_cnt = 0 and the tick counter cleared.
  - rxd_s = 1 → IDLE. This is glitch rejection; no outputs change.
- DATA:
  - Every 16 ticks, sample rxd_s into a shift register: shift right, new bit enters at the MSB.
  - bit_cnt increments after each sample.
  - When bit_cnt reaches DATA_BITS-1 and that bit is sampled → STOP.
- STOP:
  - After 16 ticks, sample rxd_s.
  - rxd_s = 1 and rx_fifo_full = 0: on the next clk, rx_data = shift register and rx_valid = 1 for exactly one cycle. Then → IDLE.
  - rxd_s = 1 and rx_fifo_full = 1: byte dropped, no rx_valid, overrun_err set to 1. Then → IDLE.
  - rxd_s = 0: framing_err pulses for one cycle, no rx_valid. Then → WAIT_IDLE.
- WAIT_IDLE:
  - Stays here while rxd_s = 0; a break condition generates no repeated errors.
  - rxd_s = 1 → IDLE.
- rx_data holds its value until the next valid byte.
- overrun_err:
  - Cleared by err_clr.
  - If a set event and err_clr occur in the same cycle, the set wins (overrun_err stays 1).
- Latency:
  - rx_valid rises 2 (sync) + 1 clk after the mid-stop-bit sample tick.
  - In total this is about 9.5 bit periods after the falling edge at the pin.
- Back-to-back frames:
  - A new start bit may arrive immediately after the stop sample.
  - Leaving STOP → IDLE takes 1 clk, so no start edge is missed.
- busy = 1 in START, DATA, STOP and WAIT_IDLE.

Decomposition:
- Shared package uart_pkg:
  - State enum IDLE, START, DATA, STOP, WAIT_IDLE.
  - Constants OVERSAMPLE = 16 and HALF_BIT = 8.
  - Default BAUD_DIV, shared with the transmitter.
- Sub-module uart_baud_tick:
  - Parameterised BAUD_DIV counter with a synchronous clear input and a tick output.
  - Reusable by the TX side.

Test Plan (BAUD_DIV = 4, so 64 clk per bit):
- Byte 0xA5, 8N1, rx_fifo_full = 0 → exactly one rx_valid pulse with rx_data = 0xA5, about 611 clk after the start edge. framing_err and overrun_err stay 0.
- rxd low for 20 clk then high (glitch shorter than half a bit) → state returns to IDLE, no rx_valid, no error pulse, busy falls after the START sample.
- Byte 0x3C with the stop bit driven 0 for 3 bit times → one framing_err pulse, no rx_valid, busy held until rxd returns high. A following 0x12 frame is received correctly.
- rx_fifo_full = 1 during byte 0x55 → no rx_valid, overrun_err = 1 and it stays set. err_clr pulse → 0. err_clr in the same cycle as a new overrun → stays 1.
- Back-to-back 0x00 then 0xFF with no idle gap → two rx_valid pulses carrying 0x00 and 0xFF, in order.
- reset asserted during DATA bit 4 of 0xC3 → all outputs 0 on the next clk, no rx_valid for 0xC3. A subsequent 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding
// Contents: OVERSAMPLE ticks per bit, HALF_BIT mid-bit offset, default baud divider, FSM state type
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int HALF_BIT = OVERSAMPLE / 2;
  localparam int BAUD_DIV_DEFAULT = 27;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, one-clk pulse every BAUD_DIV clocks
// Ports: i_clk clock, i_reset sync active-high reset, i_clr sync clear (holds count at 0), o_tick pulse
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  output logic o_tick
);
  localparam int W = $clog2(BAUD_DIV);
  logic [W-1:0] r_cnt;
  assign o_tick = !i_clr && r_cnt == W'(BAUD_DIV - 1);
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) r_cnt <= '0;
    else r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling, FIFO write strobe and error flags
// Ports: clk, reset (sync active-high), rxd serial in, rx_fifo_full, err_clr clears overrun_err,
//        rx_data/rx_valid byte strobe, framing_err pulse, overrun_err sticky, busy when not IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 rx_fifo_full,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  logic                 r_sync1, r_sync2;
  state_t               r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_valid, r_ferr, r_ovr;
  logic                 w_tick, w_rxd_s, w_sample, w_ovr_set;
  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .i_clk(clk),
    .i_reset(reset),
    .i_clr(r_state == IDLE),
    .o_tick(w_tick)
  );
  assign w_rxd_s = r_sync2;
  // START samples at mid start bit; later states sample once per full bit period
  assign w_sample = w_tick && r_tick_cnt == (r_state == START ? TW'(HALF_BIT - 1) : TW'(OVERSAMPLE - 1));
  assign w_ovr_set = r_state == STOP && w_sample && w_rxd_s && rx_fifo_full;
  assign rx_data = r_data;
  assign rx_valid = r_valid;
  assign framing_err = r_ferr;
  assign overrun_err = r_ovr;
  assign busy = r_state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr <= w_ovr_set | (r_ovr & ~err_clr);
      r_tick_cnt <= (r_state == IDLE || (r_state == START && w_sample)) ? '0 : r_tick_cnt + TW'(w_tick);
      case (r_state)
        IDLE: if (!w_rxd_s) r_state <= START;
        START: if (w_sample) begin
          r_state <= w_rxd_s ? IDLE : DATA;
          r_bit_cnt <= '0;
        end
        DATA: if (w_sample) begin
          r_shift <= DATA_BITS'({w_rxd_s, r_shift} >> 1);
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == BW'(DATA_BITS - 1)) r_state <= STOP;
        end
        STOP: if (w_sample) begin
          if (w_rxd_s) begin
            r_state <= IDLE;
            if (!rx_fifo_full) begin
              r_valid <= 1'b1;
              r_data <= r_shift;
            end
          end else begin
            r_ferr <= 1'b1;
            r_state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: if (w_rxd_s) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at BAUD_DIV=4 (64 clk per bit)
module tb_uart_rx;
  localparam int BD = 4;
  localparam int BIT = 64;
  logic clk = 0, reset = 1, rxd = 1, rx_fifo_full = 0, err_clr = 0;
  logic [7:0] rx_data;
  logic rx_valid, framing_err, overrun_err, busy;
  int checks = 0, failures = 0, n_valid = 0, n_ferr = 0, cyc_cnt = 0, last_valid_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  uart_rx #(.BAUD_DIV(BD), .DATA_BITS(8)) dut (
    .clk(clk),
    .reset(reset),
    .rxd(rxd),
    .rx_fifo_full(rx_fifo_full),
    .err_clr(err_clr),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .framing_err(framing_err),
    .overrun_err(overrun_err),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      last_valid_cyc = cyc_cnt;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid got=%h expected=none", rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (rx_data !== exp_b) begin
          failures++;
          $display("FAIL rx_data got=%h expected=%h", rx_data, exp_b);
        end
      end
    end
    if (framing_err) n_ferr++;
  end
  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len);
    rxd = 0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_clk(BIT);
    end
    rxd = stop_v;
    wait_clk(stop_len);
  endtask
  task automatic test_reset();
    reset = 1;
    wait_clk(3);
    checks += 5;
    if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h expected=00", rx_data); end
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b expected=0", rx_valid); end
    if (framing_err !== 1'b0) begin failures++; $display("FAIL reset_framing_err got=%b expected=0", framing_err); end
    if (overrun_err !== 1'b0) begin failures++; $display("FAIL reset_overrun_err got=%b expected=0", overrun_err); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
    reset = 0;
    wait_clk(5);
  endtask
  task automatic test_basic();
    int v0, f0, c0, lat;
    v0 = n_valid; f0 = n_ferr;
    exp_q.push_back(8'hA5);
    c0 = cyc_cnt;
    send_frame(8'hA5, 1'b1, BIT);
    wait_clk(BIT);
    lat = last_valid_cyc - c0;
    checks += 4;
    if (n_valid !== v0 + 1) begin failures++; $display("FAIL basic_valid_count got=%0d expected=%0d", n_valid - v0, 1); end
    if (lat < 605 || lat > 617) begin failures++; $display("FAIL basic_latency got=%0d expected=611", lat); end
    if (n_ferr !== f0) begin failures++; $display("FAIL basic_framing got=%0d expected=0", n_ferr - f0); end
    if (overrun_err !== 1'b0) begin failures++; $display("FAIL basic_overrun got=%b expected=0", overrun_err); end
  endtask
  task automatic test_glitch();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    rxd = 0;
    wait_clk(10);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_high got=%b expected=1", busy); end
    wait_clk(10);
    rxd = 1;
    wait_clk(30);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_low got=%b expected=0", busy); end
    wait_clk(100);
    checks += 2;
    if (n_valid !== v0) begin failures++; $display("FAIL glitch_valid got=%0d expected=0", n_valid - v0); end
    if (n_ferr !== f0) begin failures++; $display("FAIL glitch_framing got=%0d expected=0", n_ferr - f0); end
  endtask
  task automatic test_framing();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 3 * BIT);
    checks += 3;
    if (busy !== 1'b1) begin failures++; $display("FAIL framing_busy_held got=%b expected=1", busy); end
    if (n_ferr !== f0 + 1) begin failures++; $display("FAIL framing_pulses got=%0d expected=1", n_ferr - f0); end
    if (n_valid !== v0) begin failures++; $display("FAIL framing_valid got=%0d expected=0", n_valid - v0); end
    rxd = 1;
    wait_clk(6);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL framing_busy_release got=%b expected=0", busy); end
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, BIT);
    wait_clk(BIT);
    checks += 2;
    if (n_valid !== v0 + 1) begin failures++; $display("FAIL framing_next_valid got=%0d expected=1", n_valid - v0); end
    if (n_ferr !== f0 + 1) begin failures++; $display("FAIL framing_next_err got=%0d expected=1", n_ferr - f0); end
  endtask
  task automatic test_overrun();
    int v0;
    v0 = n_valid;
    rx_fifo_full = 1;
    send_frame(8'h55, 1'b1, BIT);
    rx_fifo_full = 0;
    checks += 2;
    if (overrun_err !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b expected=1", overrun_err); end
    if (n_valid !== v0) begin failures++; $display("FAIL overrun_valid got=%0d expected=0", n_valid - v0); end
    wait_clk(100);
    checks++;
    if (overrun_err !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b expected=1", overrun_err); end
    err_clr = 1;
    wait_clk(1);
    err_clr = 0;
    checks++;
    if (overrun_err !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b expected=0", overrun_err); end
    rx_fifo_full = 1;
    fork
      send_frame(8'h55, 1'b1, BIT);
      begin
        wait_clk(610);
        err_clr = 1;
        wait_clk(1);
        err_clr = 0;
      end
    join
    rx_fifo_full = 0;
    checks += 2;
    if (overrun_err !== 1'b1) begin failures++; $display("FAIL overrun_set_wins got=%b expected=1", overrun_err); end
    if (n_valid !== v0) begin failures++; $display("FAIL overrun_valid2 got=%0d expected=0", n_valid - v0); end
    err_clr = 1;
    wait_clk(1);
    err_clr = 0;
    wait_clk(10);
  endtask
  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, BIT);
    send_frame(8'hFF, 1'b1, BIT);
    wait_clk(BIT);
    checks++;
    if (n_valid !== v0 + 2) begin failures++; $display("FAIL b2b_valid_count got=%0d expected=2", n_valid - v0); end
  endtask
  task automatic test_reset_mid();
    int v0, f0;
    logic [7:0] d;
    v0 = n_valid; f0 = n_ferr;
    d = 8'hC3;
    rxd = 0;
    wait_clk(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      wait_clk(BIT);
    end
    rxd = d[4];
    wait_clk(32);
    reset = 1;
    wait_clk(1);
    checks += 5;
    if (rx_data !== 8'h00) begin failures++; $display("FAIL midreset_rx_data got=%h expected=00", rx_data); end
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL midreset_rx_valid got=%b expected=0", rx_valid); end
    if (framing_err !== 1'b0) begin failures++; $display("FAIL midreset_framing got=%b expected=0", framing_err); end
    if (overrun_err !== 1'b0) begin failures++; $display("FAIL midreset_overrun got=%b expected=0", overrun_err); end
    if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b expected=0", busy); end
    rxd = 1;
    reset = 0;
    wait_clk(200);
    checks += 2;
    if (n_valid !== v0) begin failures++; $display("FAIL midreset_no_valid got=%0d expected=0", n_valid - v0); end
    if (n_ferr !== f0) begin failures++; $display("FAIL midreset_no_err got=%0d expected=0", n_ferr - f0); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, BIT);
    wait_clk(BIT);
    checks++;
    if (n_valid !== v0 + 1) begin failures++; $display("FAIL midreset_next_valid got=%0d expected=1", n_valid - v0); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
